// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: MEM-stage FSM states, default widths and the
// MEM/WB register bundle handed to write-back.
package pipeline_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic                  RegWrite;
        logic                  MemtoReg;
        logic [DATA_W_DEF-1:0] memdata;
        logic [DATA_W_DEF-1:0] alu;
        logic [REG_W_DEF-1:0]  regdst;
    } mem_wb_t;

    // Word accesses only: the two low address bits must be zero.
    function automatic logic is_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears the whole bundle and wins over
// a load; with neither asserted the register holds its contents.
module mem_wb_reg
    import pipeline_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  logic    bubble,
    input  mem_wb_t d,
    output mem_wb_t q
);

    // Register the bundle, inserting an all-zero bubble when requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch/jump redirect, load/store over a req/ack data
// memory port with timeout abort, pipeline stall while an access is
// outstanding, and the MEM/WB register.
// Optional build macro FORWARD_PORTS_EN adds combinational forwarding
// outputs (MEM_RegWrite, MEMRegRd, MEM_aluval) describing the instruction
// currently in EX/MEM; loads are excluded because their data is not ready.
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              valid_in,
    input  logic              branch_in,
    input  logic              jump_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic [DATA_W-1:0] add_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic              aluzero_in,
    input  logic [DATA_W-1:0] readdata2_in,
    input  logic [REG_W-1:0]  regdst_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              pcsrc,
    output logic [DATA_W-1:0] branch_target,
    output logic              stall,
    output logic              err_out,
    output logic              valid_out,
    output logic              RegWrite_out,
    output logic              MemtoReg_out,
    output logic [DATA_W-1:0] memdata_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [REG_W-1:0]  regdst_out
`ifdef FORWARD_PORTS_EN
   ,output logic              MEM_RegWrite,
    output logic [REG_W-1:0]  MEMRegRd,
    output logic [DATA_W-1:0] MEM_aluval
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic               err_q;

    logic [DATA_W-1:0]  cap_addr;
    logic [DATA_W-1:0]  cap_wdata;
    logic               cap_we;
    logic               cap_load;
    logic               cap_regwrite;
    logic               cap_memtoreg;
    logic [REG_W-1:0]   cap_regdst;

    logic               acc;
    logic               timed_out;
    logic               start;
    logic               cnt_inc;
    logic               set_err;
    logic               wb_bubble;
    mem_wb_t            wb_d;
    mem_wb_t            wb_q;

    assign acc           = valid_in & (MemRead_in | MemWrite_in);
    assign timed_out     = (cnt == CNT_W'(TIMEOUT));
    assign pcsrc         = valid_in & ((branch_in & aluzero_in) | jump_in);
    assign branch_target = add_in;
    assign err_out       = err_q;

    // State register; reset abandons any outstanding access.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, memory port drive, stall and MEM/WB input selection.
    always_comb begin
        next_state = state;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        stall      = 1'b0;
        start      = 1'b0;
        cnt_inc    = 1'b0;
        set_err    = 1'b0;
        wb_bubble  = 1'b0;
        wb_d       = '0;
        if (!RST) begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        wb_bubble = 1'b1;
                        if (!is_aligned(alu_in[1:0])) begin
                            set_err = 1'b1;
                        end else begin
                            dmem_req   = 1'b1;
                            dmem_we    = MemWrite_in;
                            dmem_addr  = alu_in;
                            dmem_wdata = readdata2_in;
                            stall      = 1'b1;
                            start      = 1'b1;
                            next_state = WAIT;
                        end
                    end else begin
                        wb_d.valid    = valid_in;
                        wb_d.RegWrite = RegWrite_in & valid_in;
                        wb_d.MemtoReg = MemtoReg_in;
                        wb_d.alu      = alu_in;
                        wb_d.regdst   = regdst_in;
                    end
                end
                WAIT: begin
                    dmem_req   = 1'b1;
                    dmem_we    = cap_we;
                    dmem_addr  = cap_addr;
                    dmem_wdata = cap_wdata;
                    if (dmem_ack) begin
                        wb_d.valid    = 1'b1;
                        wb_d.RegWrite = cap_regwrite;
                        wb_d.MemtoReg = cap_memtoreg;
                        wb_d.memdata  = cap_load ? dmem_rdata : '0;
                        wb_d.alu      = cap_addr;
                        wb_d.regdst   = cap_regdst;
                        next_state    = IDLE;
                    end else if (timed_out) begin
                        set_err    = 1'b1;
                        wb_bubble  = 1'b1;
                        next_state = IDLE;
                    end else begin
                        stall     = 1'b1;
                        wb_bubble = 1'b1;
                        cnt_inc   = 1'b1;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Capture the access at issue, run the wait counter and hold the sticky error.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt          <= '0;
            err_q        <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            cap_we       <= 1'b0;
            cap_load     <= 1'b0;
            cap_regwrite <= 1'b0;
            cap_memtoreg <= 1'b0;
            cap_regdst   <= '0;
        end else begin
            if (set_err) begin
                err_q <= 1'b1;
            end
            if (start) begin
                cnt          <= CNT_W'(1);
                cap_addr     <= alu_in;
                cap_wdata    <= readdata2_in;
                cap_we       <= MemWrite_in;
                cap_load     <= ~MemWrite_in;
                cap_regwrite <= RegWrite_in;
                cap_memtoreg <= MemtoReg_in;
                cap_regdst   <= regdst_in;
            end else if (cnt_inc) begin
                cnt <= cnt + CNT_W'(1);
            end else if (state == WAIT) begin
                cnt <= '0;
            end
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk    (CLK),
        .rst    (RST),
        .load   (1'b1),
        .bubble (wb_bubble),
        .d      (wb_d),
        .q      (wb_q)
    );

    assign valid_out    = wb_q.valid;
    assign RegWrite_out = wb_q.RegWrite;
    assign MemtoReg_out = wb_q.MemtoReg;
    assign memdata_out  = wb_q.memdata;
    assign alu_out      = wb_q.alu;
    assign regdst_out   = wb_q.regdst;

`ifdef FORWARD_PORTS_EN
    assign MEM_RegWrite = valid_in & RegWrite_in & ~MemRead_in;
    assign MEMRegRd     = regdst_in;
    assign MEM_aluval   = alu_in;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed and randomized instructions driven into
// EX/MEM, a memory responder with random wait states, and a scoreboard that
// compares every retiring MEM/WB entry against a reference memory model.
module tb_mem_stage;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int TIMEOUT = 15;

    localparam int K_ALU    = 0;
    localparam int K_LOAD   = 1;
    localparam int K_STORE  = 2;
    localparam int K_BRANCH = 3;
    localparam int K_JUMP   = 4;
    localparam int K_BUBBLE = 5;

    typedef struct {
        logic        rw;
        logic        mtr;
        logic [31:0] md;
        logic [31:0] alu;
        logic [4:0]  rd;
    } exp_t;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              valid_in, branch_in, jump_in, MemRead_in, MemWrite_in;
    logic              RegWrite_in, MemtoReg_in, aluzero_in, dmem_ack;
    logic [DATA_W-1:0] add_in, alu_in, readdata2_in, dmem_rdata;
    logic [REG_W-1:0]  regdst_in;
    logic              dmem_req, dmem_we, pcsrc, stall, err_out;
    logic              valid_out, RegWrite_out, MemtoReg_out;
    logic [DATA_W-1:0] dmem_addr, dmem_wdata, branch_target, memdata_out, alu_out;
    logic [REG_W-1:0]  regdst_out;
`ifdef FORWARD_PORTS_EN
    logic              MEM_RegWrite;
    logic [REG_W-1:0]  MEMRegRd;
    logic [DATA_W-1:0] MEM_aluval;
`endif

    int          check_count  = 0;
    int          error_count  = 0;
    logic        exp_err      = 1'b0;
    logic        expect_bubble = 1'b0;
    exp_t        exp_q[$];
    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] phys_mem [logic [31:0]];

    mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .valid_in(valid_in), .branch_in(branch_in), .jump_in(jump_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .add_in(add_in), .alu_in(alu_in), .aluzero_in(aluzero_in),
        .readdata2_in(readdata2_in), .regdst_in(regdst_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .pcsrc(pcsrc), .branch_target(branch_target), .stall(stall),
        .err_out(err_out), .valid_out(valid_out), .RegWrite_out(RegWrite_out),
        .MemtoReg_out(MemtoReg_out), .memdata_out(memdata_out),
        .alu_out(alu_out), .regdst_out(regdst_out)
`ifdef FORWARD_PORTS_EN
       ,.MEM_RegWrite(MEM_RegWrite), .MEMRegRd(MEMRegRd), .MEM_aluval(MEM_aluval)
`endif
    );

    // Free-running clock, 10 time units per cycle.
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic driveIdle();
        valid_in = 0; branch_in = 0; jump_in = 0; MemRead_in = 0; MemWrite_in = 0;
        RegWrite_in = 0; MemtoReg_in = 0; aluzero_in = 0; dmem_ack = 0;
        add_in = '0; alu_in = '0; readdata2_in = '0; regdst_in = '0; dmem_rdata = '0;
    endtask

    // Issue one instruction into EX/MEM and act as data memory until it leaves.
    task automatic applyStimulus(input int kind, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [4:0] rd,
                                 input int lat, input logic zero,
                                 input logic [31:0] target);
        logic        is_mem;
        logic        exp_pc;
        logic [31:0] v;
        exp_t        e;
        int          last;
        @(negedge CLK);
        if (expect_bubble) begin
            checkOutput("valid_out_after_error", valid_out, 0);
            expect_bubble = 1'b0;
        end
        is_mem       = (kind == K_LOAD) || (kind == K_STORE);
        valid_in     = (kind != K_BUBBLE);
        branch_in    = (kind == K_BRANCH);
        jump_in      = (kind == K_JUMP);
        MemRead_in   = (kind == K_LOAD);
        MemWrite_in  = (kind == K_STORE);
        RegWrite_in  = (kind == K_ALU) || (kind == K_LOAD);
        MemtoReg_in  = (kind == K_LOAD);
        add_in       = target;
        alu_in       = addr;
        aluzero_in   = zero;
        readdata2_in = data;
        regdst_in    = rd;
        dmem_rdata   = $urandom;
        dmem_ack     = is_mem ? 1'b0 : 1'($urandom_range(0, 1));
        #1;
        exp_pc = ((kind == K_BRANCH) && zero) || (kind == K_JUMP);
        checkOutput("pcsrc", pcsrc, exp_pc);
        checkOutput("branch_target", branch_target, target);
        checkOutput("err_out", err_out, exp_err);
`ifdef FORWARD_PORTS_EN
        checkOutput("fwd_MEM_RegWrite", MEM_RegWrite, kind == K_ALU);
        checkOutput("fwd_MEMRegRd", MEMRegRd, rd);
        checkOutput("fwd_MEM_aluval", MEM_aluval, addr);
`endif
        if (!is_mem) begin
            checkOutput("idle_req", dmem_req, 0);
            checkOutput("idle_stall", stall, 0);
            if (kind != K_BUBBLE) begin
                e.rw = (kind == K_ALU); e.mtr = 0; e.md = 0; e.alu = addr; e.rd = rd;
                exp_q.push_back(e);
            end
        end else if (addr[1:0] != 2'b00) begin
            checkOutput("misaligned_req", dmem_req, 0);
            checkOutput("misaligned_stall", stall, 0);
            exp_err       = 1'b1;
            expect_bubble = 1'b1;
        end else begin
            if (kind == K_LOAD && !ref_mem.exists(addr)) begin
                v = $urandom;
                ref_mem[addr]  = v;
                phys_mem[addr] = v;
            end
            checkOutput("issue_req", dmem_req, 1);
            checkOutput("issue_we", dmem_we, kind == K_STORE);
            checkOutput("issue_addr", dmem_addr, addr);
            if (kind == K_STORE) checkOutput("issue_wdata", dmem_wdata, data);
            checkOutput("issue_stall", stall, 1);
            last = (lat < TIMEOUT) ? lat : TIMEOUT;
            for (int k = 1; k <= last; k++) begin
                @(negedge CLK);
                dmem_ack   = (k == lat);
                dmem_rdata = (kind == K_LOAD && phys_mem.exists(dmem_addr)) ?
                             phys_mem[dmem_addr] : $urandom;
                #1;
                checkOutput("wait_req", dmem_req, 1);
                checkOutput("wait_addr", dmem_addr, addr);
                checkOutput("wait_we", dmem_we, kind == K_STORE);
                if (kind == K_STORE) checkOutput("wait_wdata", dmem_wdata, data);
                checkOutput("wait_stall", stall, (k != lat) && (k != TIMEOUT));
                if (k == lat) begin
                    if (kind == K_STORE) begin
                        phys_mem[dmem_addr] = dmem_wdata;
                        ref_mem[addr]       = data;
                    end
                    e.rw  = (kind == K_LOAD);
                    e.mtr = (kind == K_LOAD);
                    e.md  = (kind == K_LOAD) ? ref_mem[addr] : 32'h0;
                    e.alu = addr;
                    e.rd  = rd;
                    exp_q.push_back(e);
                end
            end
            if (lat > TIMEOUT) begin
                exp_err       = 1'b1;
                expect_bubble = 1'b1;
            end
        end
    endtask

    // Assert reset while a load is waiting and check everything clears at once.
    task automatic resetDuringWait();
        @(negedge CLK);
        driveIdle();
        valid_in = 1; MemRead_in = 1; RegWrite_in = 1; MemtoReg_in = 1;
        alu_in = 32'h44; regdst_in = 5'd3;
        #1;
        checkOutput("rstwait_req_issue", dmem_req, 1);
        @(negedge CLK);
        #1;
        checkOutput("rstwait_req_held", dmem_req, 1);
        checkOutput("rstwait_stall_held", stall, 1);
        RST = 1'b1;
        #1;
        checkOutput("rstwait_req", dmem_req, 0);
        checkOutput("rstwait_stall", stall, 0);
        checkOutput("rstwait_err", err_out, 0);
        checkOutput("rstwait_valid", valid_out, 0);
        checkOutput("rstwait_regwrite", RegWrite_out, 0);
        checkOutput("rstwait_alu", alu_out, 0);
        driveIdle();
        @(negedge CLK);
        RST           = 1'b0;
        exp_err       = 1'b0;
        expect_bubble = 1'b0;
    endtask

    // Scoreboard monitor: every retiring instruction must match the oldest expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST && valid_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_count++;
                    error_count++;
                    $display("[TB] FAIL unexpected_retire: got valid_out=1 alu_out=0x%08h, expected no retiring instruction", alu_out);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("wb_RegWrite", RegWrite_out, e.rw);
                    checkOutput("wb_MemtoReg", MemtoReg_out, e.mtr);
                    checkOutput("wb_memdata", memdata_out, e.md);
                    checkOutput("wb_alu", alu_out, e.alu);
                    checkOutput("wb_regdst", regdst_out, e.rd);
                end
            end
        end
    end

    // Hard time limit so a broken design can never hang the run.
    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    // Main stimulus sequence.
    initial begin : stimulus
        int kind;
        driveIdle();
        valid_in = 1; MemRead_in = 1; alu_in = 32'h40;
        repeat (2) @(negedge CLK);
        #1;
        checkOutput("reset_req", dmem_req, 0);
        checkOutput("reset_stall", stall, 0);
        checkOutput("reset_err", err_out, 0);
        checkOutput("reset_valid", valid_out, 0);
        checkOutput("reset_regwrite", RegWrite_out, 0);
        checkOutput("reset_memtoreg", MemtoReg_out, 0);
        checkOutput("reset_memdata", memdata_out, 0);
        checkOutput("reset_alu", alu_out, 0);
        checkOutput("reset_regdst", regdst_out, 0);
        driveIdle();
        @(negedge CLK);
        RST = 1'b0;

        ref_mem[32'h40]  = 32'hCAFEBABE;
        phys_mem[32'h40] = 32'hCAFEBABE;
        applyStimulus(K_ALU,    32'h1234, 32'h0,    5'd7, 0, 0, 32'h0);
        applyStimulus(K_LOAD,   32'h40,   32'h0,    5'd9, 3, 0, 32'h0);
        applyStimulus(K_STORE,  32'h80,   32'hDEAD, 5'd0, 1, 0, 32'h0);
        applyStimulus(K_LOAD,   32'h80,   32'h0,    5'd4, 2, 0, 32'h0);
        applyStimulus(K_BRANCH, 32'h0,    32'h0,    5'd0, 0, 1, 32'h100);
        applyStimulus(K_BRANCH, 32'h5,    32'h0,    5'd0, 0, 0, 32'h100);
        applyStimulus(K_JUMP,   32'h0,    32'h0,    5'd0, 0, 0, 32'h200);
        applyStimulus(K_BUBBLE, 32'h0,    32'h0,    5'd0, 0, 1, 32'h0);

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 5);
            if (kind == K_LOAD || kind == K_STORE)
                applyStimulus(kind, 32'h40 + 32'($urandom_range(0, 15)) * 4, $urandom,
                              5'($urandom), $urandom_range(1, 4), 1'($urandom), $urandom);
            else
                applyStimulus(kind, $urandom, $urandom, 5'($urandom), 0,
                              1'($urandom), $urandom);
        end

        applyStimulus(K_LOAD,   32'h42, 32'h0, 5'd2, 1, 0, 32'h0);
        applyStimulus(K_BUBBLE, 32'h0,  32'h0, 5'd0, 0, 0, 32'h0);
        resetDuringWait();
        applyStimulus(K_LOAD,   32'h48, 32'h0, 5'd6, TIMEOUT + 5, 0, 32'h0);
        applyStimulus(K_ALU,    32'h55, 32'h0, 5'd5, 0, 0, 32'h0);
        applyStimulus(K_STORE,  32'h4C, 32'h77, 5'd0, TIMEOUT, 0, 32'h0);
        applyStimulus(K_LOAD,   32'h4C, 32'h0, 5'd8, 2, 0, 32'h0);
        repeat (3) applyStimulus(K_BUBBLE, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0);
        @(negedge CLK);
        #1;
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
